bird_datapath: RTL

- Datapath partner of the bird control FSM. Consumes the FSM's 3-bit state code and produces that FSM's `flag` ("keep rising") and `touched` (collision) inputs.
- Holds the bird's vertical position and applies rise/fall motion on each frame tick.
- Checks ground, ceiling and pipe collisions.
- Sweeps the bird sprite (erase old position, draw new) into the VGA plotter interface.

---
 rtl/bird_datapath_pkg.sv | 36 +++
 rtl/bird_datapath_sprite_sweeper.sv | 131 +++++++++++++
 rtl/bird_datapath.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bird_datapath_pkg.sv
// Shared definitions for the bird game: control-FSM state codes, screen limits,
// sprite geometry and the colours used by the plotter.
package bird_datapath_pkg;

    localparam int SCREEN_W       = 160;
    localparam int SCREEN_H       = 120;

    localparam int BIRD_X         = 20;
    localparam int BIRD_SIZE      = 4;
    localparam int BIRD_SIZE_LOG2 = 2;
    localparam int PIX_CNT_W      = 2 * BIRD_SIZE_LOG2;
    localparam int Y_MAX          = SCREEN_H - 1;
    localparam int Y_FLOOR        = Y_MAX - BIRD_SIZE + 1;
    localparam int START_Y        = 60;
    localparam int RISE_PIX       = 12;
    localparam int RISE_W         = $clog2(RISE_PIX + 1);
    localparam int FALL_STEP      = 1;

    localparam logic [2:0] BIRD_COLOUR  = 3'b110;
    localparam logic [2:0] ERASE_COLOUR = 3'b000;

    typedef enum logic [2:0] {
        S_STOP    = 3'b001,
        S_START   = 3'b010,
        S_FALLING = 3'b011,
        S_RAISING = 3'b110,
        S_DRAW    = 3'b111
    } fsm_state_e;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_ERASE = 2'd1,
        D_DRAW  = 2'd2
    } draw_state_e;

endpackage

// File: rtl/bird_datapath_sprite_sweeper.sv
// Erase-then-draw sweep of the square bird sprite, one pixel per cycle.
// Plot outputs are registered from the next-state values so they line up with the FSM state.
module sprite_sweeper
    import bird_datapath_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       abort_i,
    input  logic       start_i,
    input  logic [7:0] base_x_i,
    input  logic [6:0] base_y_i,
    input  logic [2:0] colour_i,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic [2:0] colour_o,
    output logic       plot_o,
    output logic       busy_o
);

    localparam int PIX_LAST = BIRD_SIZE * BIRD_SIZE - 1;

    draw_state_e state_q, state_d;
    logic [PIX_CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0] old_y_q, old_y_d;
    logic [6:0] new_y_q, new_y_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic [BIRD_SIZE_LOG2-1:0] row_d, col_d;
    logic       last_pix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= D_IDLE;
            cnt_q    <= '0;
            old_y_q  <= 7'(START_Y);
            new_y_q  <= 7'(START_Y);
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            old_y_q  <= old_y_d;
            new_y_q  <= new_y_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
        end
    end

    assign last_pix = (cnt_q == PIX_CNT_W'(PIX_LAST));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        old_y_d = old_y_q;
        new_y_d = new_y_q;
        case (state_q)
            D_IDLE: begin
                if (start_i) begin
                    state_d = D_ERASE;
                    cnt_d   = '0;
                    new_y_d = base_y_i;
                end
            end
            D_ERASE: begin
                cnt_d = cnt_q + 1'b1;
                if (last_pix) begin
                    state_d = D_DRAW;
                    cnt_d   = '0;
                end
            end
            D_DRAW: begin
                cnt_d = cnt_q + 1'b1;
                if (last_pix) begin
                    state_d = D_IDLE;
                    cnt_d   = '0;
                    old_y_d = new_y_q;
                end
            end
            default: begin
                state_d = D_IDLE;
                cnt_d   = '0;
            end
        endcase
        if (abort_i) begin
            state_d = D_IDLE;
            cnt_d   = '0;
            old_y_d = 7'(START_Y);
        end
    end

    // Counter is {row, col}: the low bits walk across a sprite row.
    assign row_d = cnt_d[PIX_CNT_W-1:BIRD_SIZE_LOG2];
    assign col_d = cnt_d[BIRD_SIZE_LOG2-1:0];

    always_comb begin
        x_d      = '0;
        y_d      = '0;
        colour_d = ERASE_COLOUR;
        plot_d   = 1'b0;
        case (state_d)
            D_ERASE: begin
                plot_d   = 1'b1;
                x_d      = base_x_i + 8'(col_d);
                y_d      = old_y_d + 7'(row_d);
                colour_d = ERASE_COLOUR;
            end
            D_DRAW: begin
                plot_d   = 1'b1;
                x_d      = base_x_i + 8'(col_d);
                y_d      = new_y_d + 7'(row_d);
                colour_d = colour_i;
            end
            default: begin
                plot_d = 1'b0;
            end
        endcase
    end

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign colour_o = colour_q;
    assign plot_o   = plot_q;
    assign busy_o   = plot_q;

endmodule

// File: rtl/bird_datapath.sv
// Bird physics (position, rise counter, collision) feeding the control FSM,
// plus frame-tick scheduling of the sprite sweeper.
module bird_datapath
    import bird_datapath_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] state,
    input  logic       press_key,
    input  logic       frame_tick,
    input  logic [7:0] pipe_x,
    input  logic [7:0] pipe_w,
    input  logic [6:0] gap_top,
    input  logic [6:0] gap_bot,
    output logic       flag,
    output logic       touched,
    output logic [6:0] bird_y,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       draw_busy
);

    fsm_state_e st;
    logic [6:0]        bird_y_q, bird_y_d;
    logic [RISE_W-1:0] rise_cnt_q, rise_cnt_d;
    logic              touched_q, touched_d;
    logic              tick_q;
    logic              pending_q, pending_d;
    logic              sweep_busy;
    logic              draw_start;

    logic [8:0] top9, bot9, fall9, pipe_l9, pipe_end9;
    logic       hit_ceiling, hit_ground, col_overlap, outside_gap, collide;

    assign st = fsm_state_e'(state);

    // All geometry in 9 bits so sums of 8-bit operands never wrap.
    assign top9      = {2'b00, bird_y_q};
    assign bot9      = top9 + 9'(BIRD_SIZE - 1);
    assign fall9     = top9 + 9'(FALL_STEP);
    assign pipe_l9   = {1'b0, pipe_x};
    assign pipe_end9 = pipe_l9 + {1'b0, pipe_w};

    assign hit_ceiling = (bird_y_q == '0);
    assign hit_ground  = (bot9 >= 9'(Y_MAX));
    assign col_overlap = (pipe_w != '0) && (9'(BIRD_X) < pipe_end9)
                         && (pipe_l9 <= 9'(BIRD_X + BIRD_SIZE - 1));
    assign outside_gap = (top9 < {2'b00, gap_top}) || (bot9 > {2'b00, gap_bot});
    assign collide     = hit_ceiling | hit_ground | (col_overlap & outside_gap);

    always_ff @(posedge clk) begin
        if (reset) begin
            bird_y_q   <= 7'(START_Y);
            rise_cnt_q <= '0;
            touched_q  <= 1'b0;
            tick_q     <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            bird_y_q   <= bird_y_d;
            rise_cnt_q <= rise_cnt_d;
            touched_q  <= touched_d;
            tick_q     <= frame_tick;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        bird_y_d   = bird_y_q;
        rise_cnt_d = rise_cnt_q;
        touched_d  = touched_q;
        case (st)
            S_START: begin
                bird_y_d   = 7'(START_Y);
                rise_cnt_d = '0;
                touched_d  = 1'b0;
            end
            S_RAISING, S_FALLING: begin
                touched_d = touched_q | collide;
                if (frame_tick) begin
                    if (rise_cnt_q != '0) begin
                        bird_y_d   = (bird_y_q == '0) ? '0 : bird_y_q - 7'd1;
                        rise_cnt_d = rise_cnt_q - 1'b1;
                    end else if (fall9 >= 9'(Y_FLOOR)) begin
                        bird_y_d = 7'(Y_FLOOR);
                    end else begin
                        bird_y_d = fall9[6:0];
                    end
                end
                // A key press wins over the decrement in the same cycle.
                if (press_key) begin
                    rise_cnt_d = RISE_W'(RISE_PIX);
                end
            end
            default: begin
                bird_y_d = bird_y_q;
            end
        endcase
    end

    // A tick arriving while a sweep is running (or being launched) is remembered once.
    assign draw_start = (tick_q | pending_q) & ~sweep_busy & (st != S_START);

    always_comb begin
        pending_d = pending_q;
        if (draw_start) begin
            pending_d = 1'b0;
        end
        if (frame_tick && (sweep_busy || draw_start)) begin
            pending_d = 1'b1;
        end
        if (st == S_START) begin
            pending_d = 1'b0;
        end
    end

    sprite_sweeper u_sweeper (
        .clk      (clk),
        .reset    (reset),
        .abort_i  (st == S_START),
        .start_i  (draw_start),
        .base_x_i (8'(BIRD_X)),
        .base_y_i (bird_y_q),
        .colour_i (BIRD_COLOUR),
        .x_o      (x),
        .y_o      (y),
        .colour_o (colour),
        .plot_o   (plot),
        .busy_o   (sweep_busy)
    );

    assign draw_busy = sweep_busy;
    assign flag      = (rise_cnt_q != '0);
    assign touched   = touched_q;
    assign bird_y    = bird_y_q;

endmodule
